// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
// Contents:
//   arb_state_t : arbitration mode (NORMAL = CPU priority, FORCE = display slot)
//   owner_t     : which requester owns the read data returning next cycle
//   REQ_*       : bit positions of the requesters in grant vectors
package dmem_arb_pkg;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DISP = 2'd2
    } owner_t;

    localparam int REQ_CPU  = 0;
    localparam int REQ_DISP = 1;
    localparam int NUM_REQ  = 2;

endpackage

// File: rtl/dmem_starve_counter.sv
// rtl/dmem_starve_counter.sv - saturating display wait counter with force request
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   pending      : display request is present this cycle
//   granted      : display request is granted this cycle
//   force_grant  : request denied for the last allowed cycle; next cycle must serve it
module dmem_starve_counter #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic pending,
    input  logic granted,
    output logic force_grant
);

    localparam int             CW   = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]  SAT  = CW'(MAX_WAIT);
    localparam logic [CW-1:0]  LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!pending || granted) begin
            wait_cnt <= '0;
        end else if (wait_cnt != SAT) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    // Fires in the cycle that completes the MAX_WAIT-th consecutive denial.
    assign force_grant = pending && !granted && (wait_cnt >= LAST);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - arbitrates the single-port data memory between CPU and display
// Ports:
//   clk, reset                          : clock, asynchronous active-low reset
//   cpu_read/cpu_write/cpu_addr/cpu_wdata : CPU load/store request (held while cpu_stall)
//   cpu_stall, cpu_rvalid, cpu_rdata    : CPU backpressure and 1-cycle load response
//   disp_req/disp_addr                  : display read request (level, held until disp_ack)
//   disp_ack, disp_rdata                : display grant pulse and held read word
//   err_conflict, err_addr              : error pulses (read+write together, address >= DEPTH)
//   mem_read/mem_write/read_address/write_address/write_data/mem_data : dmemory interface
module dmem_arbiter #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 1024,
    parameter int MAX_WAIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_read,
    input  logic             cpu_write,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic             cpu_stall,
    output logic             cpu_rvalid,
    output logic [WIDTH-1:0] cpu_rdata,
    input  logic             disp_req,
    input  logic [WIDTH-1:0] disp_addr,
    output logic             disp_ack,
    output logic [WIDTH-1:0] disp_rdata,
    output logic             err_conflict,
    output logic             err_addr,
    output logic             mem_read,
    output logic             mem_write,
    output logic [WIDTH-1:0] read_address,
    output logic [WIDTH-1:0] write_address,
    output logic [WIDTH-1:0] write_data,
    input  logic [WIDTH-1:0] mem_data
);

    import dmem_arb_pkg::*;

    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

    arb_state_t         state_q, state_d;
    owner_t             owner_q, owner_d;
    logic               bad_q, bad_d;
    logic [WIDTH-1:0]   disp_rdata_q;
    logic [NUM_REQ-1:0] gnt;
    logic               force_disp;

    logic cpu_conflict, cpu_valid, cpu_addr_bad, disp_addr_bad;

    // A read+write pair is consumed as an error, so only a single op is a real request.
    assign cpu_conflict  = cpu_read & cpu_write;
    assign cpu_valid     = cpu_read ^ cpu_write;
    assign cpu_addr_bad  = (cpu_addr >= DEPTH_W);
    assign disp_addr_bad = (disp_addr >= DEPTH_W);

    dmem_starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk         (clk),
        .reset       (reset),
        .pending     (disp_req),
        .granted     (gnt[REQ_DISP]),
        .force_grant (force_disp)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_NORMAL;
            owner_q      <= OWN_NONE;
            bad_q        <= 1'b0;
            disp_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            bad_q   <= bad_d;
            if (owner_q == OWN_DISP) begin
                disp_rdata_q <= bad_q ? '0 : mem_data;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = OWN_NONE;
        bad_d         = 1'b0;
        gnt           = '0;
        cpu_stall     = 1'b0;
        disp_ack      = 1'b0;
        err_conflict  = 1'b0;
        err_addr      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        read_address  = '0;
        write_address = '0;
        write_data    = '0;

        // Request-driven outputs are held at zero while reset is asserted.
        if (reset) begin
            err_conflict = cpu_conflict;

            case (state_q)
                ST_NORMAL: begin
                    gnt[REQ_CPU]  = cpu_valid;
                    gnt[REQ_DISP] = disp_req & ~cpu_valid;
                    if (force_disp) begin
                        state_d = ST_FORCE;
                    end
                end
                ST_FORCE: begin
                    gnt[REQ_DISP] = disp_req;
                    gnt[REQ_CPU]  = cpu_valid & ~disp_req;
                    cpu_stall     = cpu_valid & disp_req;
                    state_d       = ST_NORMAL;
                end
                default: state_d = ST_NORMAL;
            endcase

            if (gnt[REQ_CPU]) begin
                if (cpu_addr_bad) begin
                    err_addr = 1'b1;
                    // A bad load still answers, with zero data.
                    if (cpu_read) begin
                        owner_d = OWN_CPU;
                        bad_d   = 1'b1;
                    end
                end else if (cpu_write) begin
                    mem_write     = 1'b1;
                    write_address = cpu_addr;
                    write_data    = cpu_wdata;
                end else begin
                    mem_read     = 1'b1;
                    read_address = cpu_addr;
                    owner_d      = OWN_CPU;
                end
            end else if (gnt[REQ_DISP]) begin
                disp_ack = 1'b1;
                owner_d  = OWN_DISP;
                bad_d    = disp_addr_bad;
                err_addr = disp_addr_bad;
                if (!disp_addr_bad) begin
                    mem_read     = 1'b1;
                    read_address = disp_addr;
                end
            end
        end
    end

    assign cpu_rvalid = (owner_q == OWN_CPU);
    assign cpu_rdata  = (cpu_rvalid && !bad_q) ? mem_data : '0;
    assign disp_rdata = disp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 1024;
    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        disp_req;
    logic [31:0] disp_addr;
    logic        disp_ack;
    logic [31:0] disp_rdata;
    logic        err_conflict, err_addr;
    logic        mem_read, mem_write;
    logic [31:0] read_address, write_address, write_data;
    logic [31:0] mem_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_read      (cpu_read),
        .cpu_write     (cpu_write),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_stall     (cpu_stall),
        .cpu_rvalid    (cpu_rvalid),
        .cpu_rdata     (cpu_rdata),
        .disp_req      (disp_req),
        .disp_addr     (disp_addr),
        .disp_ack      (disp_ack),
        .disp_rdata    (disp_rdata),
        .err_conflict  (err_conflict),
        .err_addr      (err_addr),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .read_address  (read_address),
        .write_address (write_address),
        .write_data    (write_data),
        .mem_data      (mem_data)
    );

    // Unwritten words read back as a recognisable address pattern.
    function automatic logic [31:0] pattern(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    // dmemory stand-in: synchronous write, registered read data.
    logic [31:0] env_mem     [0:1023];
    bit          env_written [0:1023];
    always @(posedge clk) begin
        if (mem_write && write_address < 32'd1024) begin
            env_mem[write_address[9:0]]     <= write_data;
            env_written[write_address[9:0]] <= 1'b1;
        end
        if (mem_read && read_address < 32'd1024)
            mem_data <= env_written[read_address[9:0]] ? env_mem[read_address[9:0]] : pattern(read_address);
        else
            mem_data <= 32'hBAD0_BAD0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic any_out();
        return |{cpu_stall, cpu_rvalid, cpu_rdata, disp_ack, disp_rdata, err_conflict, err_addr,
                 mem_read, mem_write, read_address, write_address, write_data};
    endfunction

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic dr, input logic [31:0] da);
        cpu_read  = cr;
        cpu_write = cw;
        cpu_addr  = ca;
        cpu_wdata = cd;
        disp_req  = dr;
        disp_addr = da;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        cr, cw;
        logic [31:0] ca, cd;
        logic        dr;
        logic [31:0] da;
        logic        mr, mw;
        logic [31:0] ra, wa, wd;
        logic        ack, ec, ea;
        logic        rv;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [11];

    // Reference-model state for the random phase.
    logic [31:0] ref_mem [int];
    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pattern(a);
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) == 0)
            return ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : 32'd1024 + $urandom_range(0, 3000);
        return 32'd16 + $urandom_range(0, 15);
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        cr, cw, dreq;
        logic [31:0] ca, cd, da;
        logic        prev_stall, prev_ack;
        logic        m_rv, n_rv, dpend;
        logic [31:0] m_rd, n_rd, m_disp, dpend_val;
        logic        m_cval, m_forced, m_cpu, m_dg, c_ok, d_ok;
        logic        e_mr, e_mw, e_stall, e_ea;
        int          streak, busy, acks;

        //      cr    cw    ca       cd            dr    da       mr    mw    ra     wa     wd            ack   ec    ea    rv    rd
        vecs[0]  = '{1'b0, 1'b1, 32'd5,    32'hDEADBEEF, 1'b0, 32'd0,    1'b0, 1'b1, 32'd0, 32'd5,  32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[1]  = '{1'b1, 1'b0, 32'd5,    32'd0,        1'b0, 32'd0,    1'b1, 1'b0, 32'd5, 32'd0,  32'd0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 1'b0, 32'd0,    32'd0,        1'b1, 32'd7,    1'b1, 1'b0, 32'd7, 32'd0,  32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[3]  = '{1'b1, 1'b0, 32'd9,    32'd0,        1'b1, 32'd7,    1'b1, 1'b0, 32'd9, 32'd0,  32'd0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h1000_0009};
        vecs[4]  = '{1'b1, 1'b1, 32'd3,    32'h55,       1'b0, 32'd0,    1'b0, 1'b0, 32'd0, 32'd0,  32'd0,        1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[5]  = '{1'b1, 1'b1, 32'd3,    32'h55,       1'b1, 32'd4,    1'b1, 1'b0, 32'd4, 32'd0,  32'd0,        1'b1, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[6]  = '{1'b1, 1'b0, 32'd1024, 32'd0,        1'b0, 32'd0,    1'b0, 1'b0, 32'd0, 32'd0,  32'd0,        1'b0, 1'b0, 1'b1, 1'b1, 32'd0};
        vecs[7]  = '{1'b0, 1'b1, 32'd2000, 32'h77,       1'b0, 32'd0,    1'b0, 1'b0, 32'd0, 32'd0,  32'd0,        1'b0, 1'b0, 1'b1, 1'b0, 32'd0};
        vecs[8]  = '{1'b0, 1'b0, 32'd0,    32'd0,        1'b1, 32'd1024, 1'b0, 1'b0, 32'd0, 32'd0,  32'd0,        1'b1, 1'b0, 1'b1, 1'b0, 32'd0};
        vecs[9]  = '{1'b0, 1'b1, 32'd10,   32'h1234,     1'b1, 32'd11,   1'b0, 1'b1, 32'd0, 32'd10, 32'h1234,     1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[10] = '{1'b0, 1'b0, 32'd0,    32'd0,        1'b0, 32'd0,    1'b0, 1'b0, 32'd0, 32'd0,  32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 32'd0};

        // Reset state
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        #3;
        chk("reset_outputs_during", any_out(), 1'b0);
        @(posedge clk);
        cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("reset_outputs_after", any_out(), 1'b0);

        // Table of single grant cycles, each followed by an idle response cycle
        for (int i = 0; i < 11; i++) begin
            cyc();
            drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd, vecs[i].dr, vecs[i].da);
            @(negedge clk);
            chk($sformatf("vec%0d_mem_read", i),     mem_read,     vecs[i].mr);
            chk($sformatf("vec%0d_mem_write", i),    mem_write,    vecs[i].mw);
            if (vecs[i].mr) chk($sformatf("vec%0d_read_address", i), read_address, vecs[i].ra);
            if (vecs[i].mw) begin
                chk($sformatf("vec%0d_write_address", i), write_address, vecs[i].wa);
                chk($sformatf("vec%0d_write_data", i),    write_data,    vecs[i].wd);
            end
            chk($sformatf("vec%0d_cpu_stall", i),    cpu_stall,    1'b0);
            chk($sformatf("vec%0d_disp_ack", i),     disp_ack,     vecs[i].ack);
            chk($sformatf("vec%0d_err_conflict", i), err_conflict, vecs[i].ec);
            chk($sformatf("vec%0d_err_addr", i),     err_addr,     vecs[i].ea);
            cyc();
            drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_cpu_rvalid", i), cpu_rvalid, vecs[i].rv);
            if (vecs[i].rv) chk($sformatf("vec%0d_cpu_rdata", i), cpu_rdata, vecs[i].rd);
            chk($sformatf("vec%0d_err_pulse_gone", i), {err_conflict, err_addr}, 2'b00);
        end

        // Display read of addr 5 with the CPU idle; word held afterwards
        cyc();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd5);
        @(negedge clk);
        chk("disp_ack_same_cycle", disp_ack, 1'b1);
        cyc();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        chk("disp_rdata_not_yet", disp_rdata, 32'd0);
        chk("disp_ack_one_cycle", disp_ack, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc();
            @(negedge clk);
            chk($sformatf("disp_rdata_hold%0d", i), disp_rdata, 32'hDEADBEEF);
        end

        // Starvation: CPU loads every cycle, display held throughout
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            logic exp_ack;
            cyc();
            drive(1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 32'd16 + acks);
            @(negedge clk);
            exp_ack = (i == 8) || (i == 17);
            chk($sformatf("starve%0d_ack", i),   disp_ack,  exp_ack);
            chk($sformatf("starve%0d_stall", i), cpu_stall, exp_ack);
            chk($sformatf("starve%0d_raddr", i), read_address, exp_ack ? 32'd16 + acks : 32'd1);
            if (exp_ack) acks++;
        end
        cyc();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        cyc();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd16);
        @(negedge clk);
        chk("pre_random_ack", disp_ack, 1'b1);
        cyc();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        cyc();
        @(negedge clk);
        chk("pre_random_disp_rdata", disp_rdata, pattern(32'd16));

        // Random traffic against the reference model
        m_disp = pattern(32'd16);
        m_rv = 1'b0; m_rd = '0; dpend = 1'b0; dpend_val = '0;
        streak = 0; prev_stall = 1'b0; prev_ack = 1'b0; dreq = 1'b0;
        cr = 1'b0; cw = 1'b0; ca = '0; cd = '0; da = '0;
        for (int c = 0; c < 400; c++) begin
            cyc();
            if (!prev_stall) begin
                busy = (c < 200) ? 90 : 40;
                cr = 1'b0; cw = 1'b0;
                if ($urandom_range(0, 99) < busy) begin
                    int y;
                    y = $urandom_range(0, 19);
                    if (y == 0)      begin cr = 1'b1; cw = 1'b1; end
                    else if (y < 12) cr = 1'b1;
                    else             cw = 1'b1;
                end
                ca = rand_addr();
                cd = $urandom;
            end
            if (!dreq || prev_ack) begin
                dreq = ($urandom_range(0, 1) == 1);
                da   = rand_addr();
            end
            drive(cr, cw, ca, cd, dreq, da);

            m_cval   = cr ^ cw;
            m_forced = dreq && (streak >= MAX_WAIT);
            m_cpu    = m_cval && !m_forced;
            m_dg     = dreq && !m_cpu;
            c_ok     = (ca < DEPTH);
            d_ok     = (da < DEPTH);
            e_mr     = (m_cpu && cr && c_ok) || (m_dg && d_ok);
            e_mw     = m_cpu && cw && c_ok;
            e_stall  = m_cval && m_forced;
            e_ea     = (m_cpu && !c_ok) || (m_dg && !d_ok);

            @(negedge clk);
            chk("rnd_mem_read",     mem_read,     e_mr);
            chk("rnd_mem_write",    mem_write,    e_mw);
            chk("rnd_exclusive",    mem_read & mem_write, 1'b0);
            if (e_mr) chk("rnd_read_address", read_address, (m_cpu && cr) ? ca : da);
            if (e_mw) begin
                chk("rnd_write_address", write_address, ca);
                chk("rnd_write_data",    write_data,    cd);
            end
            chk("rnd_cpu_stall",    cpu_stall,    e_stall);
            chk("rnd_disp_ack",     disp_ack,     m_dg);
            chk("rnd_err_conflict", err_conflict, cr & cw);
            chk("rnd_err_addr",     err_addr,     e_ea);
            chk("rnd_cpu_rvalid",   cpu_rvalid,   m_rv);
            if (m_rv) chk("rnd_cpu_rdata", cpu_rdata, m_rd);
            chk("rnd_disp_rdata",   disp_rdata,   m_disp);

            n_rv = m_cpu && cr;
            n_rd = c_ok ? ref_read(ca) : 32'd0;
            if (dpend) m_disp = dpend_val;
            dpend     = m_dg;
            dpend_val = d_ok ? ref_read(da) : 32'd0;
            if (e_mw) ref_mem[int'(ca)] = cd;
            m_rv = n_rv;
            m_rd = n_rd;
            streak     = (dreq && !m_dg) ? streak + 1 : 0;
            prev_stall = e_stall;
            prev_ack   = m_dg;
        end
        cyc();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        cyc();

        // Reset asserted between a load grant and its response
        cyc();
        drive(1'b1, 1'b0, 32'd2, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        chk("rstmid_load_granted", mem_read, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("rstmid_outputs_during", any_out(), 1'b0);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_rvalid", cpu_rvalid, 1'b0);
        chk("rstmid_outputs_after", any_out(), 1'b0);
        cyc();
        @(negedge clk);
        chk("rstmid_outputs_later", any_out(), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
